pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
//  Responder side of the motor-controller PWM handshake. Accepts pwm_update/pwm_ratio/pwm_direction
//  from the PID controller and drives the H-bridge PWM and direction pins.
//  A new ratio takes effect only at a PWM period boundary, so the output is glitch-free; each applied
//  update is acknowledged with a one-cycle pwm_done pulse. Direction reversals insert a dead band.
// PARAMETERS
//  CLK_DIV   8   clocks per PWM tick (>=1); PWM period = 255*CLK_DIV clocks
//  DEADTIME  16  ticks with pwm_signal forced low before a direction change takes effect (>=1)
// PORTS
//  clock          in   1  main clock
//  reset_n        in   1  reset, asynchronous, active-low
//  pwm_enable     in   1  1 = drive motor; 0 = output held low, counters cleared
//  pwm_update     in   1  request: capture pwm_ratio/pwm_direction (sampled every clock)
//  pwm_ratio      in   8  requested high time, out of 255
//  pwm_direction  in   1  requested motor direction
//  pwm_done       out  1  one-cycle pulse: pending request has been applied
//  pwm_signal     out  1  PWM drive to H-bridge
//  pwm_dir_out    out  1  direction drive to H-bridge
//  busy           out  1  request pending or dead band active
// BEHAVIOUR
//  Reset: pwm_signal=0, pwm_dir_out=0, pwm_done=0, busy=0, active_ratio=0, pending=0,
//   tick_cnt=0, pwm_cnt=0, state=IDLE. All outputs are registered.
//  Tick: tick_cnt counts 0..CLK_DIV-1; tick=1 when tick_cnt==CLK_DIV-1. Counts only in RUN/DEAD.
//  pwm_cnt[7:0]: advances on tick, 0..254, then wraps to 0. Boundary = tick with pwm_cnt==254.
//  pwm_signal (RUN) = (pwm_cnt < active_ratio); ratio 0 -> constant 0, ratio 255 -> constant 1.
//  Capture: pwm_update=1 on an edge -> pend_ratio/pend_dir <= inputs, pending <= 1. A repeat
//   while pending overwrites (latest wins); only one pwm_done is issued for the merged request.
//  States:
//   IDLE (pwm_enable=0): pwm_signal=0, tick_cnt=pwm_cnt=0. If pending: apply immediately on the
//    next edge (active_ratio, pwm_dir_out <= pend_*), pending<=0, pwm_done pulses the cycle after.
//    pwm_enable=1 -> RUN with pwm_cnt=0, tick_cnt=0.
//   RUN: at boundary with pending and pend_dir==pwm_dir_out: active_ratio<=pend_ratio,
//    pending<=0, pwm_done pulses next cycle. With pend_dir!=pwm_dir_out -> DEAD.
//   DEAD: pwm_signal=0; count DEADTIME ticks; on the last one, pwm_dir_out<=pend_dir,
//    active_ratio<=pend_ratio, pending<=0, pwm_cnt<=0, pwm_done pulses, -> RUN.
//   pwm_enable=0 in RUN or DEAD -> IDLE on the next edge; pwm_signal low that same edge; a pending
//    request is kept and applied by the IDLE rule.
//  Simultaneous events: pwm_update on a boundary or final-DEAD cycle -> the old pending value is
//   applied; the new value becomes the next pending request (pending stays 1).
//  Latency, RUN, same direction: pwm_done <= 255*CLK_DIV+2 clocks after pwm_update.
//  busy = pending | (state==DEAD). pwm_done never asserts without a preceding capture.
//  Reset mid-operation: all state cleared, pending request discarded, no pwm_done issued.
// TESTING (CLK_DIV=2, DEADTIME=4)
//  1 enable=1, update ratio=64 dir=0 -> applied at next boundary; pwm_signal high 128 of 510
//    clocks per period; exactly one pwm_done pulse.
//  2 ratio=0 then ratio=255 -> pwm_signal constant 0, then constant 1, with no glitch at the wrap.
//  3 ratio=100 dir=0 running, update ratio=100 dir=1 -> at boundary pwm_signal=0 for 8 clocks,
//    then pwm_dir_out=1, PWM restarts at pwm_cnt=0, one pwm_done.
//  4 two updates (50 then 200) within one period -> 200 applied, single pwm_done.
//  5 update on the boundary cycle while 50 is pending -> 50 applied with pwm_done; 200 applied at
//    next boundary with a second pwm_done.
//  6 enable=0 mid-period -> pwm_signal=0 next edge; update ratio=30 dir=1 in IDLE -> pwm_done 2
//    clocks later; reset_n low during DEAD -> all outputs 0, no pwm_done.

Source files
------------

// File: rtl/pwm_generator.sv
// PWM responder for the motor-controller handshake: drives H-bridge pwm_signal/pwm_dir_out from requests.
// Latency: a request is applied at the next PWM period boundary (IDLE: next clock); pwm_done one clock after capture edge at the earliest.
// Backpressure: none on pwm_update; repeats while a request is pending overwrite it (latest wins), busy flags pending/dead band.
module pwm_generator #(
    parameter int CLK_DIV  = 8,
    parameter int DEADTIME = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_signal,
    output logic       pwm_dir_out,
    output logic       busy
);

    // Counter widths stay at least one bit so CLK_DIV=1 / DEADTIME=1 still elaborate.
    localparam int TW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);
    localparam logic [7:0]    CNT_LAST  = 8'd254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Architectural state
    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    pwm_cnt;
    logic [DW-1:0] dead_cnt;
    logic [7:0]    active_ratio;
    logic [7:0]    pend_ratio;
    logic          pend_dir;
    logic          pending;

    // Next-state values
    state_t        state_nxt;
    logic [TW-1:0] tick_cnt_nxt;
    logic [7:0]    pwm_cnt_nxt;
    logic [DW-1:0] dead_cnt_nxt;
    logic [7:0]    active_ratio_nxt;
    logic          dir_nxt;
    logic          pending_nxt;
    logic          apply;
    logic          signal_nxt;
    logic          busy_nxt;

    // Decoded timing events
    logic tick;
    logic boundary;
    logic dead_end;

    // Tick and period-boundary decode from the current counters.
    always_comb begin
        tick     = (state != IDLE) && (tick_cnt == TICK_LAST);
        boundary = (state == RUN)  && tick && (pwm_cnt == CNT_LAST);
        dead_end = (state == DEAD) && tick && (dead_cnt == DEAD_LAST);
    end

    // Next-state logic: counters, ratio/direction application and mode changes.
    always_comb begin
        state_nxt        = state;
        tick_cnt_nxt     = tick_cnt;
        pwm_cnt_nxt      = pwm_cnt;
        dead_cnt_nxt     = dead_cnt;
        active_ratio_nxt = active_ratio;
        dir_nxt          = pwm_dir_out;
        apply            = 1'b0;

        case (state)
            IDLE: begin
                // Motor not driven, so a pending request (even a reversal) applies at once.
                tick_cnt_nxt = '0;
                pwm_cnt_nxt  = '0;
                dead_cnt_nxt = '0;
                if (pending) begin
                    apply            = 1'b1;
                    active_ratio_nxt = pend_ratio;
                    dir_nxt          = pend_dir;
                end
                if (pwm_enable) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (!pwm_enable) begin
                    state_nxt    = IDLE;
                    tick_cnt_nxt = '0;
                    pwm_cnt_nxt  = '0;
                end else begin
                    tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        pwm_cnt_nxt = (pwm_cnt == CNT_LAST) ? 8'd0 : pwm_cnt + 8'd1;
                    end
                    // Ratio changes only at the wrap, so no period is ever truncated.
                    if (boundary && pending) begin
                        if (pend_dir == pwm_dir_out) begin
                            apply            = 1'b1;
                            active_ratio_nxt = pend_ratio;
                        end else begin
                            state_nxt    = DEAD;
                            dead_cnt_nxt = '0;
                        end
                    end
                end
            end

            DEAD: begin
                if (!pwm_enable) begin
                    state_nxt    = IDLE;
                    tick_cnt_nxt = '0;
                    pwm_cnt_nxt  = '0;
                    dead_cnt_nxt = '0;
                end else begin
                    tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
                    pwm_cnt_nxt  = '0;
                    if (tick) begin
                        dead_cnt_nxt = dead_cnt + 1'b1;
                    end
                    // Dead band over: flip direction and restart the period from zero.
                    if (dead_end) begin
                        apply            = 1'b1;
                        active_ratio_nxt = pend_ratio;
                        dir_nxt          = pend_dir;
                        dead_cnt_nxt     = '0;
                        state_nxt        = RUN;
                    end
                end
            end

            default: begin
                state_nxt    = IDLE;
                tick_cnt_nxt = '0;
                pwm_cnt_nxt  = '0;
                dead_cnt_nxt = '0;
            end
        endcase

        // A new capture on the apply cycle becomes the next request; otherwise apply retires it.
        if (pwm_update) begin
            pending_nxt = 1'b1;
        end else if (apply) begin
            pending_nxt = 1'b0;
        end else begin
            pending_nxt = pending;
        end

        // Outputs are registered from next-state values so they track the state without a cycle of skew.
        signal_nxt = (state_nxt == RUN) && (pwm_cnt_nxt < active_ratio_nxt);
        busy_nxt   = pending_nxt || (state_nxt == DEAD);
    end

    // State and registered outputs; reset discards any pending request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            pwm_cnt      <= '0;
            dead_cnt     <= '0;
            active_ratio <= '0;
            pend_ratio   <= '0;
            pend_dir     <= 1'b0;
            pending      <= 1'b0;
            pwm_dir_out  <= 1'b0;
            pwm_signal   <= 1'b0;
            pwm_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            tick_cnt     <= tick_cnt_nxt;
            pwm_cnt      <= pwm_cnt_nxt;
            dead_cnt     <= dead_cnt_nxt;
            active_ratio <= active_ratio_nxt;
            pending      <= pending_nxt;
            pwm_dir_out  <= dir_nxt;
            pwm_signal   <= signal_nxt;
            pwm_done     <= apply;
            busy         <= busy_nxt;
            if (pwm_update) begin
                pend_ratio <= pwm_ratio;
                pend_dir   <= pwm_direction;
            end
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator with CLK_DIV=2, DEADTIME=4.
// Requests push expected pwm_done events; a monitor pops them on each pwm_done pulse.
// Duty cycle, dead band and reset behaviour are checked against hand-computed values.
module tb_pwm_generator;

    localparam int CLK_DIV  = 2;
    localparam int DEADTIME = 4;
    localparam int PERIOD   = 255 * CLK_DIV;
    localparam int DEAD_CLK = DEADTIME * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       pwm_enable = 1'b0;
    logic       pwm_update = 1'b0;
    logic [7:0] pwm_ratio = 8'd0;
    logic       pwm_direction = 1'b0;
    logic       pwm_done;
    logic       pwm_signal;
    logic       pwm_dir_out;
    logic       busy;

    pwm_generator #(
        .CLK_DIV (CLK_DIV),
        .DEADTIME(DEADTIME)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pwm_enable   (pwm_enable),
        .pwm_update   (pwm_update),
        .pwm_ratio    (pwm_ratio),
        .pwm_direction(pwm_direction),
        .pwm_done     (pwm_done),
        .pwm_signal   (pwm_signal),
        .pwm_dir_out  (pwm_dir_out),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int ldc   = 0;

    typedef struct {
        int   ratio;
        logic dir;
        int   issue_cyc;
        int   min_lat;
        int   max_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_lat;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every pwm_done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (pwm_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: pwm_done=1 with no request outstanding at cycle %0d", cyc);
            end else begin
                mon_e   = sb.pop_front();
                mon_lat = cyc - mon_e.issue_cyc;
                check("done_dir", int'(pwm_dir_out), int'(mon_e.dir));
                total++;
                if (mon_lat < mon_e.min_lat || mon_lat > mon_e.max_lat) begin
                    bad++;
                    $display("FAIL done_latency ratio=%0d: got %0d clocks, required %0d..%0d",
                             mon_e.ratio, mon_lat, mon_e.min_lat, mon_e.max_lat);
                end
                ldc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_until(input int target);
        do step(); while (cyc < target);
    endtask

    // mode 0: no done expected, 1: new expected done, 2: merge into the outstanding one
    task automatic issue(input int r, input logic d, input int mn, input int mx, input int mode);
        exp_t e;
        e.ratio     = r;
        e.dir       = d;
        e.issue_cyc = cyc;
        e.min_lat   = mn;
        e.max_lat   = mx;
        if (mode == 1 || (mode == 2 && sb.size() == 0)) sb.push_back(e);
        else if (mode == 2) sb[sb.size()-1] = e;
        pwm_ratio     = r[7:0];
        pwm_direction = d;
        pwm_update    = 1'b1;
        @(posedge clock);
        #1;
        pwm_update = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL done_timeout: %0d request(s) outstanding after %0d clocks", sb.size(), limit);
            sb.delete();
        end
    endtask

    task automatic measure(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            step();
            if (pwm_signal === 1'b1) highs++;
        end
    endtask

    function automatic int next_boundary(input int from);
        int b;
        b = ldc;
        while (b < from) b += PERIOD;
        return b;
    endfunction

    initial begin
        int h;
        int nb;
        int c0;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_signal", int'(pwm_signal), 0);
        check("rst_dir", int'(pwm_dir_out), 0);
        check("rst_done", int'(pwm_done), 0);
        check("rst_busy", int'(busy), 0);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: ratio 64 applied at first boundary, 128 high clocks per period
        pwm_enable = 1'b1;
        issue(64, 1'b0, 2, PERIOD + 2, 1);
        wait_done(PERIOD + 20);
        measure(PERIOD, h);
        check("t1_high_count", h, 128);
        check("t1_busy_idle", int'(busy), 0);

        // 2: ratio 0 then 255
        issue(0, 1'b0, 2, PERIOD + 2, 1);
        wait_done(PERIOD + 20);
        measure(PERIOD, h);
        check("t2_ratio0_high", h, 0);
        issue(255, 1'b0, 2, PERIOD + 2, 1);
        wait_done(PERIOD + 20);
        measure(2 * PERIOD, h);
        check("t2_ratio255_high", h, 2 * PERIOD);

        // 3: direction reversal with dead band
        issue(100, 1'b0, 2, PERIOD + 2, 1);
        wait_done(PERIOD + 20);
        measure(PERIOD, h);
        check("t3_ratio100_high", h, 200);
        issue(100, 1'b1, 2, PERIOD + DEAD_CLK + 2, 1);
        nb = next_boundary(cyc + 1);
        wait_until(nb - 1);
        h = 0;
        repeat (DEAD_CLK) begin
            step();
            if (pwm_signal !== 1'b0) h++;
        end
        check("t3_dead_high_count", h, 0);
        check("t3_dir_in_dead", int'(pwm_dir_out), 0);
        check("t3_busy_in_dead", int'(busy), 1);
        step();
        check("t3_restart_signal", int'(pwm_signal), 1);
        check("t3_new_dir", int'(pwm_dir_out), 1);
        check("t3_done_pulse", int'(pwm_done), 1);
        wait_done(10);
        measure(PERIOD, h);
        check("t3_after_high", h, 200);

        // 4: two updates in one period merge, latest wins
        issue(50, 1'b1, 2, PERIOD + 2, 1);
        check("t4_busy_pending", int'(busy), 1);
        repeat (3) step();
        issue(200, 1'b1, 2, PERIOD + 2, 2);
        wait_done(PERIOD + 20);
        measure(PERIOD, h);
        check("t4_merged_high", h, 400);

        // 5: update on the boundary edge while 50 pending
        issue(50, 1'b1, 2, PERIOD + 2, 1);
        nb = next_boundary(cyc + 1);
        wait_until(nb - 1);
        issue(200, 1'b1, 2, PERIOD + 2, 1);
        step();
        check("t5_first_done", int'(pwm_done), 1);
        check("t5_still_busy", int'(busy), 1);
        wait_done(PERIOD + 20);
        measure(PERIOD, h);
        check("t5_second_high", h, 400);

        // 6: disable mid-period, IDLE update, reset during dead band
        wait_until(ldc + PERIOD + 20);
        check("t6_high_before_off", int'(pwm_signal), 1);
        pwm_enable = 1'b0;
        step();
        check("t6_low_after_off", int'(pwm_signal), 0);
        check("t6_busy_idle", int'(busy), 0);
        issue(30, 1'b1, 2, 2, 1);
        wait_done(10);
        check("t6_idle_dir", int'(pwm_dir_out), 1);
        step();
        pwm_enable = 1'b1;
        c0 = cyc;
        step();
        step();
        issue(80, 1'b0, 0, 0, 0);
        wait_until(c0 + PERIOD + 3);
        check("t6_dead_busy", int'(busy), 1);
        check("t6_dead_signal", int'(pwm_signal), 0);
        check("t6_dead_dir", int'(pwm_dir_out), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_signal", int'(pwm_signal), 0);
        check("t6_rst_dir", int'(pwm_dir_out), 0);
        check("t6_rst_done", int'(pwm_done), 0);
        check("t6_rst_busy", int'(busy), 0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (40) step();
        check("t6_post_busy", int'(busy), 0);
        check("t6_post_dir", int'(pwm_dir_out), 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
